// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants for the skid-buffered pipeline stage.
// Optional feature macro: PIPE_BUBBLE_NOP_EN (see pipe_stage_skid.sv).
package pipe_stage_skid_pkg;

  // Reset is asserted when rst equals this level.
  localparam logic RST_ENABLE = 1'b0;

  // rdy level that freezes the pipeline.
  localparam logic PAUSE_DISABLE = 1'b0;

  // RISC-V canonical NOP: addi x0, x0, 0.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload bus carrying a pc and an instruction/data word.
// The master drives the payload, the slave returns ready.
interface pipe_stage_skid_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] inst;

  modport master (output valid, output pc, output inst, input ready);
  modport slave  (input valid, input pc, input inst, output ready);
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One payload slot: valid flag plus pc/inst registers.
// Clear drops the valid flag but keeps the data; load captures a new entry.
module pipe_stage_skid_slot
  import pipe_stage_skid_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_inst,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_inst
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_inst;

  // Slot register: reset zeroes everything, clear wins over load.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer, flush and pause.
// in_ready comes only from registered state, rdy and flush, so there is no
// combinational path from downstream ready to upstream ready.
// Optional macro PIPE_BUBBLE_NOP_EN: when defined, an empty stage shows
// NOP_WORD on inst and zero on pc instead of stale main-slot contents.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] NOP_WORD = NOP_INST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  pipe_stage_skid_if.slave        up,
  pipe_stage_skid_if.master       dn
);

`ifdef PIPE_BUBBLE_NOP_EN
  localparam bit BUBBLE_EN = 1'b1;
`else
  localparam bit BUBBLE_EN = 1'b0;
`endif

  localparam logic [DATA_W-1:0] NOP_FIT = DATA_W'(NOP_WORD);

  logic              w_main_valid, w_skid_valid;
  logic [ADDR_W-1:0] w_main_pc, w_skid_pc;
  logic [DATA_W-1:0] w_main_inst, w_skid_inst;

  logic              w_run;
  logic              w_in_ready, w_out_valid;
  logic              w_accept, w_emit;
  logic              w_main_load, w_main_clear;
  logic              w_skid_load, w_skid_clear;
  logic [ADDR_W-1:0] w_main_pc_next;
  logic [DATA_W-1:0] w_main_inst_next;

  assign w_run       = (rdy != PAUSE_DISABLE) & ~flush;
  assign w_in_ready  = rdy & ~w_skid_valid & ~flush;
  assign w_out_valid = w_main_valid & rdy;
  assign w_accept    = up.valid & w_in_ready;
  assign w_emit      = w_out_valid & dn.ready;

  // Slot control: decide what each slot loads or drops this cycle.
  always_comb begin
    w_main_load      = 1'b0;
    w_main_clear     = flush;
    w_skid_load      = 1'b0;
    w_skid_clear     = flush;
    // The skid entry is always older than anything on the input.
    w_main_pc_next   = w_skid_valid ? w_skid_pc   : up.pc;
    w_main_inst_next = w_skid_valid ? w_skid_inst : up.inst;
    if (w_run) begin
      if (w_emit) begin
        if (w_skid_valid) begin
          w_main_load  = 1'b1;
          w_skid_clear = 1'b1;
        end else if (w_accept) begin
          w_main_load  = 1'b1;
        end else begin
          w_main_clear = 1'b1;
        end
      end else if (w_accept) begin
        if (w_main_valid) w_skid_load = 1'b1;
        else              w_main_load = 1'b1;
      end
    end
  end

  pipe_stage_skid_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_pc    (w_main_pc_next),
    .i_inst  (w_main_inst_next),
    .o_valid (w_main_valid),
    .o_pc    (w_main_pc),
    .o_inst  (w_main_inst)
  );

  pipe_stage_skid_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_pc    (up.pc),
    .i_inst  (up.inst),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_inst  (w_skid_inst)
  );

  assign up.ready = w_in_ready;
  assign dn.valid = w_out_valid;
  assign dn.pc    = (BUBBLE_EN && !w_main_valid) ? '0      : w_main_pc;
  assign dn.inst  = (BUBBLE_EN && !w_main_valid) ? NOP_FIT : w_main_inst;

endmodule
